edge_event_monitor: RTL and testbench

//  Per-bit edge detector for a WIDTH-bit sampled bus. Generalises $rose to all bits, with

---
 rtl/edge_event_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_edge_event_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_monitor.sv
// ---------------------------------------------------------------------------
// edge_event_monitor
//
// Per-bit edge detector for a WIDTH-bit sampled bus. It generalises $rose to
// every bit and adds a selectable edge mode, sticky per-bit flags, a
// saturating event counter and a first-event capture FSM. It sits beside a
// datapath bus as a passive, synthesizable event monitor.
//
// The monitor never reports an edge against an unsampled history. The first
// sample after reset only loads the history register.
//
// Parameters
//   WIDTH      monitored bus width in bits (>= 1)
//   CNT_W      event counter width in bits (>= 2)
//
// Ports
//   clk        in   1      clock; all state updates on posedge
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous clear of sticky, evt_cnt and capture;
//                          the FSM returns to ARMED
//   mode       in   2      00 rise, 01 fall, 10 any edge, 11 detection off
//   din        in   WIDTH  monitored bus
//   edge_vec   out  WIDTH  per-bit edge flags for the latest sample (pulse)
//   any_edge   out  1      OR of edge_vec
//   sticky     out  WIDTH  OR-accumulated edge_vec since reset/clear
//   evt_cnt    out  CNT_W  saturating sum of popcount(edge_vec)
//   cap_valid  out  1      high while the FSM holds a captured value
//   cap_data   out  WIDTH  din value at the first edge after arming
//   lsb_rose   out  1      rising edge on din[0], independent of mode
// ---------------------------------------------------------------------------
module edge_event_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] edge_vec,
    output logic             any_edge,
    output logic [WIDTH-1:0] sticky,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_data,
    output logic             lsb_rose
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_ANY  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_WARMUP   = 2'b00,
        ST_ARMED    = 2'b01,
        ST_CAPTURED = 2'b10
    } state_e;

    // Popcount of a WIDTH-bit vector needs enough bits to hold WIDTH itself.
    localparam int PC_W  = $clog2(WIDTH + 1);
    // The sum gets one spare bit above the wider operand, so the carry out of
    // an overflowing add is visible to the saturation compare.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] prev;       // din as sampled on the previous posedge
    logic             hist_ok;    // prev holds a real sample (not reset value)
    state_e           state;

    // -----------------------------------------------------------------------
    // Next-sample edge detection
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] edge_next;  // value being loaded into edge_vec
    logic             lsb_next;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path through the block leaves it unassigned and no latch is
        // inferred.
        edge_next = '0;
        if (hist_ok) begin
            case (mode_e'(mode))
                MODE_RISE: edge_next =  din & ~prev;
                MODE_FALL: edge_next = ~din &  prev;
                MODE_ANY:  edge_next =  din ^  prev;
                default:   edge_next = '0;      // MODE_OFF
            endcase
        end
    end

    // The legacy $rose view of bit 0 ignores mode but still respects history.
    assign lsb_next = hist_ok & din[0] & ~prev[0];

    // -----------------------------------------------------------------------
    // Event counting with saturation
    // -----------------------------------------------------------------------
    logic [PC_W-1:0]  edge_pop;
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        edge_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_pop = edge_pop + PC_W'(edge_next[i]);
        end
    end

    // A partial add that would pass all-ones clamps to all-ones; once there
    // the counter stays put because any non-zero addend clamps again.
    always_comb begin
        cnt_sum  = SUM_W'(evt_cnt) + SUM_W'(edge_pop);
        cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // -----------------------------------------------------------------------
    // Sampling: history register and per-sample edge outputs.
    // clear does not touch this block; a same-cycle edge is still reported.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) only, so every
    // register in these blocks sees the pre-edge value of every other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            hist_ok  <= 1'b0;
            edge_vec <= '0;
            lsb_rose <= 1'b0;
        end else begin
            prev     <= din;              // updated in every mode, including off
            hist_ok  <= 1'b1;
            edge_vec <= edge_next;
            lsb_rose <= lsb_next;
        end
    end

    assign any_edge = |edge_vec;

    // -----------------------------------------------------------------------
    // Accumulators: sticky flags and event counter.
    // clear wins over a same-cycle edge, which is therefore not accumulated.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky  <= '0;
            evt_cnt <= '0;
        end else if (clear) begin
            sticky  <= '0;
            evt_cnt <= '0;
        end else begin
            sticky  <= sticky | edge_next;
            evt_cnt <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // First-event capture FSM
    //   WARMUP   : waiting for the first history sample; leaves on the first
    //              posedge after reset whether or not clear is high.
    //   ARMED    : waiting for the first reported edge.
    //   CAPTURED : cap_data frozen until clear.
    // clear suppresses a same-cycle capture, matching the accumulators.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WARMUP;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            case (state)
                ST_WARMUP: begin
                    // edge_next is forced to zero while hist_ok is low, so
                    // nothing can be captured here.
                    state     <= ST_ARMED;
                    cap_valid <= 1'b0;
                    cap_data  <= '0;
                end

                ST_ARMED: begin
                    if (clear) begin
                        cap_valid <= 1'b0;
                        cap_data  <= '0;
                    end else if (|edge_next) begin
                        state     <= ST_CAPTURED;
                        cap_valid <= 1'b1;
                        cap_data  <= din;
                    end
                end

                ST_CAPTURED: begin
                    if (clear) begin
                        state     <= ST_ARMED;
                        cap_valid <= 1'b0;
                        cap_data  <= '0;
                    end
                end

                default: begin
                    // Unused encoding: recover through a fresh warm-up.
                    state     <= ST_WARMUP;
                    cap_valid <= 1'b0;
                    cap_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_edge_event_monitor
//
// Self-checking bench for edge_event_monitor. Two instances share inputs:
// the default WIDTH=4/CNT_W=8 build and a CNT_W=3 build for counter
// saturation. A directed table walks the main scenarios, hand-written
// sequences cover async reset and narrow-counter saturation, and a random
// run compares both instances against a behavioural model.
// ---------------------------------------------------------------------------
module tb_edge_event_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [1:0] mode;
    logic [3:0] din;

    logic [3:0] edge_vec,  sticky,  cap_data;
    logic       any_edge,  cap_valid,  lsb_rose;
    logic [7:0] evt_cnt;

    logic [3:0] edge_vec3, sticky3, cap_data3;
    logic       any_edge3, cap_valid3, lsb_rose3;
    logic [2:0] evt_cnt3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    edge_event_monitor #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .din(din),
        .edge_vec(edge_vec), .any_edge(any_edge), .sticky(sticky),
        .evt_cnt(evt_cnt), .cap_valid(cap_valid), .cap_data(cap_data),
        .lsb_rose(lsb_rose)
    );

    edge_event_monitor #(.WIDTH(4), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .din(din),
        .edge_vec(edge_vec3), .any_edge(any_edge3), .sticky(sticky3),
        .evt_cnt(evt_cnt3), .cap_valid(cap_valid3), .cap_data(cap_data3),
        .lsb_rose(lsb_rose3)
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: edges are worked out bit by bit from the previous
    // and current samples, counts are plain integers clamped with a min().
    // -----------------------------------------------------------------------
    logic [3:0] m_prev, m_edge, m_sticky, m_capd;
    bit         m_hist, m_lsb, m_capv;
    int         m_cnt8, m_cnt3;

    task automatic model_reset();
        m_prev = '0; m_edge = '0; m_sticky = '0; m_capd = '0;
        m_hist = 0;  m_lsb = 0;   m_capv = 0;
        m_cnt8 = 0;  m_cnt3 = 0;
    endtask

    task automatic model_step(input bit c, input logic [1:0] md,
                              input logic [3:0] d);
        logic [3:0] e;
        int n;
        e = '0;
        if (m_hist) begin
            for (int i = 0; i < 4; i++) begin
                case (md)
                    2'd0: e[i] = d[i] && !m_prev[i];
                    2'd1: e[i] = !d[i] && m_prev[i];
                    2'd2: e[i] = d[i] != m_prev[i];
                    default: e[i] = 1'b0;
                endcase
            end
        end
        m_lsb = m_hist && d[0] && !m_prev[0];
        if (c) begin
            m_sticky = '0; m_cnt8 = 0; m_cnt3 = 0; m_capv = 0; m_capd = '0;
        end else begin
            n = $countones(e);
            m_sticky = m_sticky | e;
            m_cnt8 = (m_cnt8 + n > 255) ? 255 : m_cnt8 + n;
            m_cnt3 = (m_cnt3 + n > 7) ? 7 : m_cnt3 + n;
            if (!m_capv && e != 0) begin
                m_capv = 1;
                m_capd = d;
            end
        end
        m_edge = e;
        m_prev = d;
        m_hist = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, " edge_vec"},  32'(edge_vec),  32'(m_edge));
        check({tag, " any_edge"},  32'(any_edge),  32'(m_edge != 0));
        check({tag, " lsb_rose"},  32'(lsb_rose),  32'(m_lsb));
        check({tag, " sticky"},    32'(sticky),    32'(m_sticky));
        check({tag, " evt_cnt"},   32'(evt_cnt),   32'(m_cnt8));
        check({tag, " cap_valid"}, 32'(cap_valid), 32'(m_capv));
        check({tag, " cap_data"},  32'(cap_data),  32'(m_capd));
        check({tag, " evt_cnt3"},  32'(evt_cnt3),  32'(m_cnt3));
        check({tag, " dut3 rest"},
              32'({edge_vec3, any_edge3, lsb_rose3, sticky3, cap_valid3, cap_data3}),
              32'({m_edge, m_edge != 0, m_lsb, m_sticky, m_capv, m_capd}));
    endtask

    // Drive one sample: inputs change away from the edge, the model advances
    // with the same inputs, outputs are sampled 1 ns after the edge.
    task automatic step(input bit c, input logic [1:0] md, input logic [3:0] d);
        clear = c; mode = md; din = d;
        @(posedge clk);
        model_step(c, md, d);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " all outputs"},
              32'({edge_vec, any_edge, sticky, cap_valid, cap_data, lsb_rose}), 32'd0);
        check({tag, " evt_cnt"},  32'(evt_cnt),  32'd0);
        check({tag, " evt_cnt3"}, 32'(evt_cnt3), 32'd0);
    endtask

    // -----------------------------------------------------------------------
    // Directed table
    // -----------------------------------------------------------------------
    typedef struct {
        bit         clr;
        logic [1:0] md;
        logic [3:0] d;
        logic [3:0] e;
        bit         lsb;
        logic [3:0] st;
        logic [7:0] cnt;
        bit         cv;
        logic [3:0] cd;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl[NVEC];

    function automatic vec_t mk(bit clr, logic [1:0] md, logic [3:0] d,
                                logic [3:0] e, bit lsb, logic [3:0] st,
                                logic [7:0] cnt, bit cv, logic [3:0] cd);
        vec_t v;
        v.clr = clr; v.md = md; v.d = d; v.e = e; v.lsb = lsb;
        v.st = st; v.cnt = cnt; v.cv = cv; v.cd = cd;
        return v;
    endfunction

    initial begin
        //           clr mode   din      edge    lsb sticky   cnt   cv  cap
        // reset with all-ones held: first sample is history only
        tbl[0]  = mk(0, 2'b00, 4'b1111, 4'b0000, 0, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[1]  = mk(0, 2'b00, 4'b1111, 4'b0000, 0, 4'b0000, 8'd0,  0, 4'b0000);
        // rise mode, alternating 0100/0101
        tbl[2]  = mk(0, 2'b00, 4'b0100, 4'b0000, 0, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[3]  = mk(0, 2'b00, 4'b0101, 4'b0001, 1, 4'b0001, 8'd1,  1, 4'b0101);
        tbl[4]  = mk(0, 2'b00, 4'b0100, 4'b0000, 0, 4'b0001, 8'd1,  1, 4'b0101);
        tbl[5]  = mk(0, 2'b00, 4'b0101, 4'b0001, 1, 4'b0001, 8'd2,  1, 4'b0101);
        tbl[6]  = mk(0, 2'b00, 4'b0100, 4'b0000, 0, 4'b0001, 8'd2,  1, 4'b0101);
        tbl[7]  = mk(0, 2'b00, 4'b0101, 4'b0001, 1, 4'b0001, 8'd3,  1, 4'b0101);
        // clear while switching to any-edge: edge shown, not accumulated
        tbl[8]  = mk(1, 2'b10, 4'b0000, 4'b0101, 0, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[9]  = mk(0, 2'b10, 4'b1111, 4'b1111, 1, 4'b1111, 8'd4,  1, 4'b1111);
        tbl[10] = mk(0, 2'b10, 4'b0000, 4'b1111, 0, 4'b1111, 8'd8,  1, 4'b1111);
        // fall mode: rising step is ignored except by lsb_rose
        tbl[11] = mk(0, 2'b01, 4'b1111, 4'b0000, 1, 4'b1111, 8'd8,  1, 4'b1111);
        tbl[12] = mk(0, 2'b01, 4'b0000, 4'b1111, 0, 4'b1111, 8'd12, 1, 4'b1111);
        // detection off: prev still follows din
        tbl[13] = mk(0, 2'b11, 4'b1010, 4'b0000, 0, 4'b1111, 8'd12, 1, 4'b1111);
        tbl[14] = mk(0, 2'b11, 4'b0101, 4'b0000, 1, 4'b1111, 8'd12, 1, 4'b1111);
        tbl[15] = mk(0, 2'b00, 4'b0101, 4'b0000, 0, 4'b1111, 8'd12, 1, 4'b1111);
        // clear on the same clock as a 0000->0011 rise: clear wins
        tbl[16] = mk(1, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[17] = mk(1, 2'b00, 4'b0011, 4'b0011, 1, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[18] = mk(0, 2'b00, 4'b0000, 4'b0000, 0, 4'b0000, 8'd0,  0, 4'b0000);
        tbl[19] = mk(0, 2'b00, 4'b0011, 4'b0011, 1, 4'b0011, 8'd2,  1, 4'b0011);
    end

    // -----------------------------------------------------------------------
    // Main sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [2:0] sat_exp [5];
        logic [3:0] sat_din [5];
        logic [3:0] rd;

        rst_n = 1'b0; clear = 1'b0; mode = 2'b00; din = 4'b1111;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("in reset");
        rst_n = 1'b1;

        // --- directed table --------------------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].clr, tbl[i].md, tbl[i].d);
            check($sformatf("row%0d edge_vec", i),  32'(edge_vec),  32'(tbl[i].e));
            check($sformatf("row%0d any_edge", i),  32'(any_edge),  32'(tbl[i].e != 0));
            check($sformatf("row%0d lsb_rose", i),  32'(lsb_rose),  32'(tbl[i].lsb));
            check($sformatf("row%0d sticky", i),    32'(sticky),    32'(tbl[i].st));
            check($sformatf("row%0d evt_cnt", i),   32'(evt_cnt),   32'(tbl[i].cnt));
            check($sformatf("row%0d cap_valid", i), 32'(cap_valid), 32'(tbl[i].cv));
            check($sformatf("row%0d cap_data", i),  32'(cap_data),  32'(tbl[i].cd));
        end

        // --- async reset mid-stream with evt_cnt=5 and a capture held ---------
        step(0, 2'b00, 4'b0000);
        step(0, 2'b00, 4'b0111);              // rise 0111 -> 2 + 3 = 5
        check("pre-reset evt_cnt", 32'(evt_cnt), 32'd5);
        check("pre-reset cap_valid", 32'(cap_valid), 32'd1);
        #2 rst_n = 1'b0;                      // between clock edges
        #1 check_all_zero("async reset");
        model_reset();
        din = 4'b1111;
        @(negedge clk) rst_n = 1'b1;
        step(0, 2'b00, 4'b1111);
        check("post-reset first edge_vec", 32'(edge_vec), 32'd0);
        check("post-reset first lsb_rose", 32'(lsb_rose), 32'd0);
        compare_all("post-reset first");
        step(0, 2'b00, 4'b0000);
        step(0, 2'b00, 4'b1111);
        check("post-reset rise edge_vec", 32'(edge_vec), 32'hF);
        check("post-reset rise evt_cnt", 32'(evt_cnt), 32'd4);

        // --- 3-bit counter saturation, any-edge toggling ---------------------
        rst_n = 1'b0; din = 4'b0000; mode = 2'b10;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        sat_din = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        sat_exp = '{3'd0, 3'd4, 3'd7, 3'd7, 3'd7};
        for (int i = 0; i < 5; i++) begin
            step(0, 2'b10, sat_din[i]);
            check($sformatf("sat%0d evt_cnt3", i), 32'(evt_cnt3), 32'(sat_exp[i]));
        end

        // --- randomized run against the model --------------------------------
        rst_n = 1'b0; clear = 1'b0; din = 4'b0000;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        rd = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            bit c;
            if (i == 400) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                compare_all("rand async reset");
                @(negedge clk) rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) != 0) rd = 4'($urandom_range(0, 15));
            // Frequent clears early, rare clears later so the 8-bit counter
            // can reach saturation.
            c = (i < 250) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 399) == 0);
            step(c, 2'($urandom_range(0, 3)), rd);
            compare_all($sformatf("rand%0d", i));
        end
        check("rand reached saturation", 32'(evt_cnt == 8'hFF || m_cnt8 < 255), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Run-away guard: the sequence above is a few thousand cycles at most.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
